picosoc_gpio: RTL and testbench

- Parametrised GPIO peripheral on the PicoSoC iomem bus; the successor to the fixed 32-bit LED register in the board tops.
- Adds per-pin output enable, atomic set/clear/toggle, synchronised inputs, and edge-capture interrupts.
- Sits beside picosoc and decodes one 16 MB iomem window; drives board pins through SB_IO or tristate buffers in the top level.

---
 rtl/picosoc_gpio_pkg.sv | 22 ++
 rtl/picosoc_gpio_sync.sv | 38 +++
 rtl/picosoc_gpio.sv | 143 ++++++++++++++
 tb/tb_picosoc_gpio.sv | 200 ++++++++++++++++++++
 4 files changed

// File: rtl/picosoc_gpio_pkg.sv
// Shared constants for the PicoSoC GPIO peripheral: register word offsets,
// the value returned by reserved offsets, and the byte-strobe expansion helper.
package picosoc_gpio_pkg;

    localparam logic [3:0] OFS_OUT     = 4'd0;
    localparam logic [3:0] OFS_IN      = 4'd1;
    localparam logic [3:0] OFS_OE      = 4'd2;
    localparam logic [3:0] OFS_SET     = 4'd3;
    localparam logic [3:0] OFS_CLR     = 4'd4;
    localparam logic [3:0] OFS_TGL     = 4'd5;
    localparam logic [3:0] OFS_RISE_EN = 4'd6;
    localparam logic [3:0] OFS_FALL_EN = 4'd7;
    localparam logic [3:0] OFS_STATUS  = 4'd8;

    localparam logic [31:0] RESERVED_RDATA = 32'h0000_0000;

    // Expand the four byte strobes into a 32-bit byte-enable mask.
    function automatic logic [31:0] strobe_bytes(input logic [3:0] wstrb);
        return {{8{wstrb[3]}}, {8{wstrb[2]}}, {8{wstrb[1]}}, {8{wstrb[0]}}};
    endfunction

endpackage

// File: rtl/picosoc_gpio_sync.sv
// Input synchroniser chain for the GPIO pins plus the previous-sample flop
// used for edge detection. Produces raw (unmasked) rise/fall pulses.
module picosoc_gpio_sync #(
    parameter int WIDTH       = 32,
    parameter int SYNC_STAGES = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] gpio_in,
    output logic [WIDTH-1:0] in_sync,
    output logic [WIDTH-1:0] rise_raw,
    output logic [WIDTH-1:0] fall_raw
);

    logic [WIDTH-1:0] sync_q [SYNC_STAGES];
    logic [WIDTH-1:0] prev_q;

    // Shift the asynchronous pins through the synchroniser and keep last IN.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < SYNC_STAGES; i++) begin
                sync_q[i] <= '0;
            end
            prev_q <= '0;
        end else begin
            sync_q[0] <= gpio_in;
            for (int i = 1; i < SYNC_STAGES; i++) begin
                sync_q[i] <= sync_q[i-1];
            end
            prev_q <= sync_q[SYNC_STAGES-1];
        end
    end

    assign in_sync  = sync_q[SYNC_STAGES-1];
    assign rise_raw = in_sync & ~prev_q;
    assign fall_raw = ~in_sync & prev_q;

endmodule

// File: rtl/picosoc_gpio.sv
// PicoSoC iomem GPIO peripheral: output/OE registers with atomic
// set/clear/toggle, synchronised inputs and edge-capture interrupt status.
module picosoc_gpio
    import picosoc_gpio_pkg::*;
#(
    parameter int          WIDTH       = 32,
    parameter logic [7:0]  BASE_ADDR   = 8'h02,
    parameter int          SYNC_STAGES = 2,
    parameter logic [31:0] RESET_OUT   = 32'h0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             iomem_valid,
    output logic             iomem_ready,
    input  logic [3:0]       iomem_wstrb,
    input  logic [31:0]      iomem_addr,
    input  logic [31:0]      iomem_wdata,
    output logic [31:0]      iomem_rdata,
    input  logic [WIDTH-1:0] gpio_in,
    output logic [WIDTH-1:0] gpio_out,
    output logic [WIDTH-1:0] gpio_oe,
    output logic             irq
);

    logic [WIDTH-1:0] out_q;
    logic [WIDTH-1:0] oe_q;
    logic [WIDTH-1:0] rise_en_q;
    logic [WIDTH-1:0] fall_en_q;
    logic [WIDTH-1:0] status_q;
    logic [WIDTH-1:0] status_next;
    logic [WIDTH-1:0] in_sync;
    logic [WIDTH-1:0] rise_raw;
    logic [WIDTH-1:0] fall_raw;
    logic [WIDTH-1:0] byte_en;
    logic [WIDTH-1:0] wmask;
    logic [WIDTH-1:0] clr_mask;
    logic [31:0]      byte_en32;
    logic [31:0]      wmask32;
    logic [31:0]      rd_value;
    logic [3:0]       ofs;
    logic             sel;
    logic             wr;
    logic             unused_addr_bits;

    picosoc_gpio_sync #(
        .WIDTH      (WIDTH),
        .SYNC_STAGES(SYNC_STAGES)
    ) u_sync (
        .clk     (clk),
        .reset   (reset),
        .gpio_in (gpio_in),
        .in_sync (in_sync),
        .rise_raw(rise_raw),
        .fall_raw(fall_raw)
    );

    assign sel       = iomem_valid && !iomem_ready && (iomem_addr[31:24] == BASE_ADDR);
    assign wr        = sel && (iomem_wstrb != 4'b0000);
    assign ofs       = iomem_addr[5:2];
    assign byte_en32 = strobe_bytes(iomem_wstrb);
    assign wmask32   = iomem_wdata & byte_en32;
    assign byte_en   = byte_en32[WIDTH-1:0];
    assign wmask     = wmask32[WIDTH-1:0];
    assign clr_mask  = (wr && ofs == OFS_STATUS) ? wmask : '0;

    assign unused_addr_bits = &{1'b0, iomem_addr[23:6], iomem_addr[1:0]};

    // Read mux: value of the addressed register before this access's write.
    always_comb begin
        rd_value = RESERVED_RDATA;
        case (ofs)
            OFS_OUT:     rd_value = 32'(out_q);
            OFS_IN:      rd_value = 32'(in_sync);
            OFS_OE:      rd_value = 32'(oe_q);
            OFS_RISE_EN: rd_value = 32'(rise_en_q);
            OFS_FALL_EN: rd_value = 32'(fall_en_q);
            OFS_STATUS:  rd_value = 32'(status_q);
            default:     rd_value = RESERVED_RDATA;
        endcase
    end

    // Edge capture: new enabled edges set bits, RW1C clears the rest.
    always_comb begin
        status_next = (status_q & ~clr_mask) | (rise_raw & rise_en_q) | (fall_raw & fall_en_q);
    end

    // Bus handshake: one-cycle ready pulse and registered read data.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            iomem_ready <= 1'b0;
            iomem_rdata <= 32'h0;
        end else begin
            iomem_ready <= sel;
            iomem_rdata <= sel ? rd_value : 32'h0;
        end
    end

    // OUT register: byte-strobed writes plus atomic set/clear/toggle.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            out_q <= RESET_OUT[WIDTH-1:0];
        end else if (wr) begin
            case (ofs)
                OFS_OUT: out_q <= (out_q & ~byte_en) | wmask;
                OFS_SET: out_q <= out_q | wmask;
                OFS_CLR: out_q <= out_q & ~wmask;
                OFS_TGL: out_q <= out_q ^ wmask;
                default: ;
            endcase
        end
    end

    // Plain byte-strobed RW control registers: OE and edge enables.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            oe_q      <= '0;
            rise_en_q <= '0;
            fall_en_q <= '0;
        end else if (wr) begin
            case (ofs)
                OFS_OE:      oe_q      <= (oe_q & ~byte_en) | wmask;
                OFS_RISE_EN: rise_en_q <= (rise_en_q & ~byte_en) | wmask;
                OFS_FALL_EN: fall_en_q <= (fall_en_q & ~byte_en) | wmask;
                default: ;
            endcase
        end
    end

    // Status and interrupt flops; irq tracks the OR of the next status.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            status_q <= '0;
            irq      <= 1'b0;
        end else begin
            status_q <= status_next;
            irq      <= |status_next;
        end
    end

    assign gpio_out = out_q;
    assign gpio_oe  = oe_q;

endmodule

// File: tb/tb_picosoc_gpio.sv
// Self-checking bench for picosoc_gpio: a 32-bit instance and an 8-bit
// instance share one bus master; expected read data goes through a queue.
module tb_picosoc_gpio;
    import picosoc_gpio_pkg::*;

    localparam logic [7:0] BASE = 8'h02;

    typedef struct packed {
        logic [3:0]  wstrb;
        logic [3:0]  ofs;
        logic [31:0] wdata;
        logic [31:0] exp;
    } vec_t;

    logic        clk = 1'b0;
    logic        reset;
    logic        iomem_valid;
    logic [3:0]  iomem_wstrb;
    logic [31:0] iomem_addr;
    logic [31:0] iomem_wdata;
    int          tgt;

    logic        valid32, valid8;
    logic        ready32, ready8, ready_m;
    logic [31:0] rdata32, rdata8, rdata_m;
    logic [31:0] gpio_in32, gpio_out32, gpio_oe32;
    logic [7:0]  gpio_in8, gpio_out8, gpio_oe8;
    logic        irq32, irq8;

    int          total = 0;
    int          bad = 0;
    logic [31:0] exp_q [$];
    vec_t        vecs [21];

    assign valid32 = iomem_valid && (tgt == 0);
    assign valid8  = iomem_valid && (tgt == 1);
    assign ready_m = (tgt == 0) ? ready32 : ready8;
    assign rdata_m = (tgt == 0) ? rdata32 : rdata8;

    always #5 clk = ~clk;

    picosoc_gpio #(
        .WIDTH(32), .BASE_ADDR(BASE), .SYNC_STAGES(2), .RESET_OUT(32'h0000_00A5)
    ) dut32 (
        .clk(clk), .reset(reset),
        .iomem_valid(valid32), .iomem_ready(ready32), .iomem_wstrb(iomem_wstrb),
        .iomem_addr(iomem_addr), .iomem_wdata(iomem_wdata), .iomem_rdata(rdata32),
        .gpio_in(gpio_in32), .gpio_out(gpio_out32), .gpio_oe(gpio_oe32), .irq(irq32)
    );

    picosoc_gpio #(
        .WIDTH(8), .BASE_ADDR(BASE), .SYNC_STAGES(2), .RESET_OUT(32'h0000_005A)
    ) dut8 (
        .clk(clk), .reset(reset),
        .iomem_valid(valid8), .iomem_ready(ready8), .iomem_wstrb(iomem_wstrb),
        .iomem_addr(iomem_addr), .iomem_wdata(iomem_wdata), .iomem_rdata(rdata8),
        .gpio_in(gpio_in8), .gpio_out(gpio_out8), .gpio_oe(gpio_oe8), .irq(irq8)
    );

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        total++;
        if (actual !== expected) begin
            bad++;
            $display("[TB] FAIL %s: got %h expected %h", name, actual, expected);
        end
    endtask

    // Runs one bus access starting at a falling edge; ends on a falling edge.
    task automatic applyStimulus(input logic [3:0] wstrb, input logic [3:0] ofs,
                                 input logic [31:0] wdata, input logic [31:0] exp, input string name);
        int          lat;
        logic [31:0] exp_v;
        lat = 0;
        exp_q.push_back(exp);
        iomem_valid = 1'b1;
        iomem_wstrb = wstrb;
        iomem_addr  = {BASE, 18'h2A5A5, ofs, 2'b11};
        iomem_wdata = wdata;
        for (int c = 1; c <= 4 && lat == 0; c++) begin
            @(negedge clk);
            if (ready_m === 1'b1) lat = c;
        end
        iomem_valid = 1'b0;
        iomem_wstrb = 4'b0000;
        exp_v = exp_q.pop_front();
        checkOutput({name, "_latency"}, 32'(lat), 32'd1);
        if (lat != 0) checkOutput({name, "_rdata"}, rdata_m, exp_v);
        @(negedge clk);
        checkOutput({name, "_ready_drop"}, 32'(ready_m), 32'd0);
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        vecs[0]  = '{4'h0, OFS_OUT,     32'h0,          32'h0000_00A5};
        vecs[1]  = '{4'h0, OFS_OE,      32'h0,          32'h0};
        vecs[2]  = '{4'h0, OFS_STATUS,  32'h0,          32'h0};
        vecs[3]  = '{4'hF, OFS_OUT,     32'h0,          32'h0000_00A5};
        vecs[4]  = '{4'h2, OFS_OUT,     32'h1234_5678,  32'h0};
        vecs[5]  = '{4'h0, OFS_OUT,     32'h0,          32'h0000_5600};
        vecs[6]  = '{4'hF, OFS_OUT,     32'h0000_00F0,  32'h0000_5600};
        vecs[7]  = '{4'hF, OFS_SET,     32'h0000_000F,  32'h0};
        vecs[8]  = '{4'h0, OFS_OUT,     32'h0,          32'h0000_00FF};
        vecs[9]  = '{4'hF, OFS_CLR,     32'h0000_0081,  32'h0};
        vecs[10] = '{4'h0, OFS_OUT,     32'h0,          32'h0000_007E};
        vecs[11] = '{4'hF, OFS_TGL,     32'h0000_00FF,  32'h0};
        vecs[12] = '{4'h0, OFS_OUT,     32'h0,          32'h0000_0081};
        vecs[13] = '{4'h0, OFS_SET,     32'h0,          32'h0};
        vecs[14] = '{4'h9, OFS_OE,      32'h5A5A_5A5A,  32'h0};
        vecs[15] = '{4'h0, OFS_OE,      32'h0,          32'h5A00_005A};
        vecs[16] = '{4'h0, OFS_IN,      32'h0,          32'h0};
        vecs[17] = '{4'hF, 4'd10,       32'hFFFF_FFFF,  32'h0};
        vecs[18] = '{4'h0, 4'd10,       32'h0,          32'h0};
        vecs[19] = '{4'hF, OFS_RISE_EN, 32'h0000_0008,  32'h0};
        vecs[20] = '{4'h0, OFS_RISE_EN, 32'h0,          32'h0000_0008};

        reset = 1'b1; tgt = 0;
        iomem_valid = 1'b0; iomem_wstrb = 4'h0; iomem_addr = 32'h0; iomem_wdata = 32'h0;
        gpio_in32 = 32'h0; gpio_in8 = 8'h0;
        repeat (3) @(negedge clk);
        checkOutput("rst_gpio_out", gpio_out32, 32'h0000_00A5);
        checkOutput("rst_gpio_oe", gpio_oe32, 32'h0);
        checkOutput("rst_irq", 32'(irq32), 32'd0);
        checkOutput("rst_ready", 32'(ready32), 32'd0);
        reset = 1'b0;
        @(negedge clk);

        for (int i = 0; i < 21; i++) begin
            applyStimulus(vecs[i].wstrb, vecs[i].ofs, vecs[i].wdata, vecs[i].exp, $sformatf("vec%0d", i));
        end
        checkOutput("pin_out", gpio_out32, 32'h0000_0081);
        checkOutput("pin_oe", gpio_oe32, 32'h5A00_005A);

        iomem_valid = 1'b1; iomem_wstrb = 4'h0; iomem_addr = {8'h03, 18'h0, OFS_OUT, 2'b00};
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            checkOutput("outside_window_ready", 32'(ready_m), 32'd0);
        end
        iomem_valid = 1'b0;
        @(negedge clk);

        gpio_in32 = 32'h0000_0008;
        @(negedge clk);
        checkOutput("rise_irq_c1", 32'(irq32), 32'd0);
        @(negedge clk);
        checkOutput("rise_irq_c2", 32'(irq32), 32'd0);
        @(negedge clk);
        checkOutput("rise_irq_c3", 32'(irq32), 32'd1);
        applyStimulus(4'h0, OFS_IN, 32'h0, 32'h0000_0008, "in_read");
        applyStimulus(4'h0, OFS_STATUS, 32'h0, 32'h0000_0008, "status_rise");
        gpio_in32 = 32'h0;
        repeat (5) @(negedge clk);
        applyStimulus(4'h0, OFS_STATUS, 32'h0, 32'h0000_0008, "status_after_fall");
        checkOutput("irq_held", 32'(irq32), 32'd1);

        gpio_in32 = 32'h0000_0008;
        @(negedge clk);
        @(negedge clk);
        applyStimulus(4'hF, OFS_STATUS, 32'h0000_0008, 32'h0000_0008, "clr_with_edge");
        applyStimulus(4'h0, OFS_STATUS, 32'h0, 32'h0000_0008, "edge_wins");
        applyStimulus(4'hF, OFS_RISE_EN, 32'h0, 32'h0000_0008, "rise_en_off");
        applyStimulus(4'h0, OFS_STATUS, 32'h0, 32'h0000_0008, "status_kept");
        applyStimulus(4'hF, OFS_STATUS, 32'h0000_0008, 32'h0000_0008, "clr_plain");
        applyStimulus(4'h0, OFS_STATUS, 32'h0, 32'h0, "status_cleared");
        checkOutput("irq_cleared", 32'(irq32), 32'd0);

        tgt = 1;
        applyStimulus(4'hF, OFS_OE, 32'hFFFF_FFFF, 32'h0, "w8_oe");
        applyStimulus(4'h0, OFS_OE, 32'h0, 32'h0000_00FF, "w8_oe_read");
        applyStimulus(4'h0, 4'd12, 32'h0, 32'h0, "w8_reserved");
        applyStimulus(4'hF, OFS_OUT, 32'h0000_003C, 32'h0000_005A, "w8_out");
        checkOutput("w8_pin_oe", 32'(gpio_oe8), 32'h0000_00FF);
        checkOutput("w8_pin_out", 32'(gpio_out8), 32'h0000_003C);

        iomem_valid = 1'b1; iomem_wstrb = 4'h0; iomem_addr = {BASE, 18'h0, OFS_OUT, 2'b00};
        reset = 1'b1;
        for (int c = 0; c < 2; c++) begin
            @(negedge clk);
            checkOutput("abort_ready", 32'(ready_m), 32'd0);
            checkOutput("abort_rdata", rdata_m, 32'h0);
        end
        iomem_valid = 1'b0;
        reset = 1'b0;
        @(negedge clk);
        checkOutput("abort_ready_after", 32'(ready_m), 32'd0);
        checkOutput("w8_rst_out", 32'(gpio_out8), 32'h0000_005A);
        checkOutput("w8_rst_oe", 32'(gpio_oe8), 32'h0);
        checkOutput("w32_rst_out", gpio_out32, 32'h0000_00A5);
        checkOutput("w32_rst_oe", gpio_oe32, 32'h0);
        applyStimulus(4'h0, OFS_OE, 32'h0, 32'h0, "w8_oe_after_rst");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
